// File: rtl/rf_wb_scoreboard.sv
// Write-back register file (8 x 16) with bypassed combinational reads and a
// per-register pending-write scoreboard that drives decode RAW stalls.
module rf_wb_scoreboard #(
  parameter int DATA_W     = 16,
  parameter int NREGS_LOG2 = 3,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREGS_LOG2-1:0] read1RegSel,
  input  logic [NREGS_LOG2-1:0] read2RegSel,
  output logic [DATA_W-1:0]     read1Data,
  output logic [DATA_W-1:0]     read2Data,
  input  logic                  writeEn,
  input  logic [NREGS_LOG2-1:0] writeRegSel,
  input  logic [DATA_W-1:0]     writeData,
  input  logic                  issueEn,
  input  logic [NREGS_LOG2-1:0] issueRegSel,
  input  logic                  flush,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  err
);
  localparam int NREGS = 1 << NREGS_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] data_all [NREGS];
  logic [CNT_W-1:0]  cnt_all  [NREGS];
  logic [NREGS-1:0]  ovf;
  logic [NREGS-1:0]  unf;
  logic              err_reg;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic              inc;
      logic              dec;
      logic [DATA_W-1:0] data_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [CNT_W-1:0]  cnt_next;
      logic              ovf_next;
      logic              unf_next;

      assign inc = issueEn && (issueRegSel == NREGS_LOG2'(gi));
      assign dec = writeEn && (writeRegSel == NREGS_LOG2'(gi));

      // Flush wins over everything; an issue and a commit together cancel out.
      always_comb begin
        cnt_next = cnt_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (flush) begin
          cnt_next = '0;
        end else if (inc && !dec) begin
          if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
          else                    cnt_next = cnt_reg + CNT_W'(1);
        end else if (dec && !inc) begin
          if (cnt_reg == '0) unf_next = 1'b1;
          else               cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (dec) data_reg <= writeData;
          cnt_reg <= cnt_next;
        end
      end

      assign data_all[gi] = data_reg;
      assign cnt_all[gi]  = cnt_reg;
      assign ovf[gi]      = ovf_next;
      assign unf[gi]      = unf_next;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_reg <= 1'b0;
    else if (|{ovf, unf}) err_reg <= 1'b1;
  end

  assign err = err_reg;

  // Reads are forced to zero while rst is held so a same-cycle write cannot leak through.
  logic hit1;
  logic hit2;
  assign hit1 = writeEn && (writeRegSel == read1RegSel);
  assign hit2 = writeEn && (writeRegSel == read2RegSel);

  always_comb begin
    read1Data = hit1 ? writeData : data_all[read1RegSel];
    read2Data = hit2 ? writeData : data_all[read2RegSel];
    if (rst) begin
      read1Data = '0;
      read2Data = '0;
    end
  end

  // cnt - dec != 0 modulo 2^CNT_W is the same as cnt != dec.
  assign busy1 = !rst && (cnt_all[read1RegSel] != CNT_W'(hit1));
  assign busy2 = !rst && (cnt_all[read2RegSel] != CNT_W'(hit2));

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_rf_wb_scoreboard;
  logic        clk;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel, issueRegSel;
  logic [15:0] read1Data, read2Data, writeData;
  logic        writeEn, issueEn, flush, busy1, busy2, err;

  typedef struct {
    string       name;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        b1;
    logic        b2;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_wb_scoreboard #(.DATA_W(16), .NREGS_LOG2(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(read1Data), .read2Data(read2Data),
    .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .issueEn(issueEn), .issueRegSel(issueRegSel), .flush(flush),
    .busy1(busy1), .busy2(busy2), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field,
                       input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %h expected %h", name, field, got, want);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs settled at posedge+1.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check(x.name, "read1Data", read1Data, x.r1);
      check(x.name, "read2Data", read2Data, x.r2);
      check(x.name, "busy1", {15'd0, busy1}, {15'd0, x.b1});
      check(x.name, "busy2", {15'd0, busy2}, {15'd0, x.b2});
      check(x.name, "err",   {15'd0, err},   {15'd0, x.e});
      $display("txn %-10s r1=%h r2=%h b1=%b b2=%b err=%b", x.name,
               read1Data, read2Data, busy1, busy2, err);
    end
  end

  // One cycle: drive inputs, queue the expected mid-cycle outputs, advance past the edge.
  task automatic cyc(input string name,
                     input logic we, input logic [2:0] ws, input logic [15:0] wd,
                     input logic ie, input logic [2:0] is, input logic fl,
                     input logic [2:0] s1, input logic [2:0] s2,
                     input logic [15:0] e1, input logic [15:0] e2,
                     input logic eb1, input logic eb2, input logic ee);
    exp_t x;
    writeEn = we; writeRegSel = ws; writeData = wd;
    issueEn = ie; issueRegSel = is; flush = fl;
    read1RegSel = s1; read2RegSel = s2;
    x.name = name; x.r1 = e1; x.r2 = e2; x.b1 = eb1; x.b2 = eb2; x.e = ee;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    writeEn = 0; writeRegSel = 0; writeData = 0;
    issueEn = 0; issueRegSel = 0; flush = 0;
    read1RegSel = 0; read2RegSel = 0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    //      name        we ws  wd        ie is fl s1 s2  r1        r2        b1 b2 e
    cyc("reset",        1, 3, 16'hFFFF, 1, 3, 0, 3, 3, 16'h0000, 16'h0000, 0, 0, 0);
    rst = 1'b0;
    cyc("iss3",         0, 0, 16'h0000, 1, 3, 0, 3, 0, 16'h0000, 16'h0000, 0, 0, 0);
    cyc("pend3",        0, 0, 16'h0000, 0, 0, 0, 3, 0, 16'h0000, 16'h0000, 1, 0, 0);
    cyc("wr3",          1, 3, 16'hBEEF, 0, 0, 0, 3, 0, 16'hBEEF, 16'h0000, 0, 0, 0);
    cyc("rd3",          0, 0, 16'h0000, 0, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 0);
    cyc("iss5",         0, 0, 16'h0000, 1, 5, 0, 5, 5, 16'h0000, 16'h0000, 0, 0, 0);
    cyc("isswr5",       1, 5, 16'h7777, 1, 5, 0, 5, 5, 16'h7777, 16'h7777, 0, 0, 0);
    cyc("bypass5",      1, 5, 16'h1234, 0, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0, 0);
    cyc("rd5",          0, 0, 16'h0000, 0, 0, 0, 5, 3, 16'h1234, 16'hBEEF, 0, 0, 0);
    cyc("iss2",         0, 0, 16'h0000, 1, 2, 0, 2, 5, 16'h0000, 16'h1234, 0, 0, 0);
    cyc("stall2a",      0, 0, 16'h0000, 0, 0, 0, 2, 5, 16'h0000, 16'h1234, 1, 0, 0);
    cyc("stall2b",      0, 0, 16'h0000, 0, 0, 0, 2, 5, 16'h0000, 16'h1234, 1, 0, 0);
    cyc("wr2",          1, 2, 16'h00AA, 0, 0, 0, 2, 5, 16'h00AA, 16'h1234, 0, 0, 0);
    cyc("rd2",          0, 0, 16'h0000, 0, 0, 0, 2, 5, 16'h00AA, 16'h1234, 0, 0, 0);
    cyc("iss4a",        0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0000, 16'h00AA, 0, 0, 0);
    cyc("iss4b",        0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0000, 16'h00AA, 1, 0, 0);
    cyc("iss4c",        0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0000, 16'h00AA, 1, 0, 0);
    cyc("wr4a",         1, 4, 16'h0001, 0, 0, 0, 4, 2, 16'h0001, 16'h00AA, 1, 0, 0);
    cyc("wr4b",         1, 4, 16'h0002, 0, 0, 0, 4, 2, 16'h0002, 16'h00AA, 1, 0, 0);
    cyc("wr4c",         1, 4, 16'h0003, 0, 0, 0, 4, 2, 16'h0003, 16'h00AA, 0, 0, 0);
    cyc("re4a",         0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0003, 16'h00AA, 0, 0, 0);
    cyc("re4b",         0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0003, 16'h00AA, 1, 0, 0);
    cyc("re4c",         0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0003, 16'h00AA, 1, 0, 0);
    cyc("ovf4",         0, 0, 16'h0000, 1, 4, 0, 4, 2, 16'h0003, 16'h00AA, 1, 0, 0);
    cyc("sat4",         1, 4, 16'h0044, 0, 0, 0, 4, 2, 16'h0044, 16'h00AA, 1, 0, 1);
    cyc("iss1a",        0, 0, 16'h0000, 1, 1, 0, 4, 1, 16'h0044, 16'h0000, 1, 0, 1);
    cyc("iss1b",        0, 0, 16'h0000, 1, 1, 0, 1, 2, 16'h0000, 16'h00AA, 1, 0, 1);
    cyc("iss2f",        0, 0, 16'h0000, 1, 2, 0, 1, 2, 16'h0000, 16'h00AA, 1, 0, 1);
    cyc("flush",        1, 1, 16'h5555, 0, 0, 1, 1, 2, 16'h5555, 16'h00AA, 1, 1, 1);
    cyc("postflush",    0, 0, 16'h0000, 0, 0, 0, 1, 4, 16'h5555, 16'h0044, 0, 0, 1);
    cyc("prerst",       0, 0, 16'h0000, 0, 0, 0, 1, 3, 16'h5555, 16'hBEEF, 0, 0, 1);
    rst = 1'b1;
    cyc("asyncrst",     1, 1, 16'hA5A5, 0, 0, 0, 1, 3, 16'h0000, 16'h0000, 0, 0, 0);
    rst = 1'b0;
    cyc("postrst",      0, 0, 16'h0000, 0, 0, 0, 1, 3, 16'h0000, 16'h0000, 0, 0, 0);
    cyc("iss6",         0, 0, 16'h0000, 1, 6, 0, 6, 5, 16'h0000, 16'h0000, 0, 0, 0);
    cyc("isswr6",       1, 6, 16'h6666, 1, 6, 0, 6, 5, 16'h6666, 16'h0000, 0, 0, 0);
    cyc("unf7",         1, 7, 16'h7A7A, 0, 0, 0, 6, 5, 16'h6666, 16'h0000, 1, 0, 0);
    cyc("rd7",          0, 0, 16'h0000, 0, 0, 0, 7, 6, 16'h7A7A, 16'h6666, 0, 1, 1);
    cyc("iss0",         0, 0, 16'h0000, 1, 0, 0, 0, 7, 16'h0000, 16'h7A7A, 0, 0, 1);
    cyc("wr0",          1, 0, 16'hC0DE, 0, 0, 0, 0, 7, 16'hC0DE, 16'h7A7A, 0, 0, 1);
    cyc("rd0",          0, 0, 16'h0000, 0, 0, 0, 0, 7, 16'hC0DE, 16'h7A7A, 0, 0, 1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
